// File: rtl/tinycpu_out_uart.sv
// Output stage for the tiny CPU: captures 16-bit words into a FIFO and
// sends each one as two 8N1 UART bytes, high byte first.
module tinycpu_out_uart #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr,
    input  logic [15:0]                   wdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          txd
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full, r_empty, r_overflow;

    logic [1:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_idx;
    logic          r_hi;
    logic [15:0]   r_hold;
    logic          r_txd, r_busy;

    logic [1:0]    w_state_nxt;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    w_idx_nxt, w_idx_inc;
    logic          w_hi_nxt;
    logic [15:0]   w_hold_nxt;
    logic          w_txd_nxt;
    logic          w_pop, w_push, w_baud_last;
    logic [7:0]    w_byte;
    logic [CW-1:0] w_count_nxt;

    assign w_push      = wr && !r_full;
    assign w_baud_last = (r_baud == BW'(CLK_DIV - 1));
    assign w_byte      = r_hi ? r_hold[15:8] : r_hold[7:0];
    assign w_idx_inc   = r_idx + 3'd1;

    // Occupancy after this edge's push/pop; status flags register from it.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Next-state logic; txd is computed for the next state so the line is registered.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_idx_nxt   = r_idx;
        w_hi_nxt    = r_hi;
        w_hold_nxt  = r_hold;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_hold_nxt  = r_mem[r_rptr];
                    w_hi_nxt    = 1'b1;
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = w_byte[0];
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_txd_nxt = w_byte[w_idx_inc];
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            default: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_hi) begin
                        w_hi_nxt    = 1'b0;
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_idx      <= 3'd0;
            r_hi       <= 1'b0;
            r_hold     <= 16'h0000;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (wr && r_full) r_overflow <= 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == CW'(0));
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_hi    <= w_hi_nxt;
            r_hold  <= w_hold_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign busy     = r_busy;
    assign txd      = r_txd;

endmodule

// File: tb/tb_tinycpu_out_uart.sv
// Directed bench for tinycpu_out_uart; a line monitor decodes frames
// independently of the DUT and each test task checks its own results.
module tb_tinycpu_out_uart;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned WORD_T     = 20 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic [15:0] wdata = 16'h0000;
    logic        full, empty, overflow, busy, txd;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0] rx_q[$];
    int          rx_st[$];
    bit          rx_ok[$];

    tinycpu_out_uart #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .wdata(wdata),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .busy(busy), .txd(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples mid-bit, abandons a frame if reset is seen.
    logic [15:0] m_w;
    bit          m_ok, m_ab;
    int          m_st, m_k;
    always begin
        @(negedge clk);
        if (reset === 1'b0 && txd === 1'b0) begin
            m_st = cyc; m_ok = 1'b1; m_ab = 1'b0; m_w = 16'h0000;
            for (int c = 1; c < 20 * CLK_DIV; c++) begin
                @(negedge clk);
                if (reset !== 1'b0) begin m_ab = 1'b1; break; end
                if (c % CLK_DIV == CLK_DIV / 2) begin
                    m_k = c / CLK_DIV;
                    if (m_k == 0 || m_k == 10)      m_ok = m_ok && (txd === 1'b0);
                    else if (m_k == 9 || m_k == 19) m_ok = m_ok && (txd === 1'b1);
                    else if (m_k < 9)               m_w[8 + m_k - 1] = txd;
                    else                            m_w[m_k - 11] = txd;
                end
            end
            if (!m_ab) begin
                rx_q.push_back(m_w); rx_st.push_back(m_st); rx_ok.push_back(m_ok);
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clear_rx;
        rx_q.delete(); rx_st.delete(); rx_ok.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1; wr = 1'b0;
        tick; tick;
        reset = 1'b0;
        tick;
        n_cmp++; if (txd !== 1'b1)      begin n_err++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (count !== 3'd0)    begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_single_word;
        logic [19:0] fr;
        logic [7:0]  hb, lb;
        hb = 8'hA5; lb = 8'h5A;
        fr = {1'b1, lb, 1'b0, 1'b1, hb, 1'b0};
        clear_rx();
        wr = 1'b1; wdata = 16'hA55A;
        tick;
        wr = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count_push: got %0d want 1", count); end
        n_cmp++; if (txd !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle_push: txd %b busy %b want 1 0", txd, busy); end
        tick;
        n_cmp++; if (busy !== 1'b1 || empty !== 1'b1 || count !== 3'd0) begin
            n_err++; $display("FAIL single_pop: busy %b empty %b count %0d want 1 1 0", busy, empty, count); end
        for (int i = 0; i < 20 * CLK_DIV; i++) begin
            if (i > 0) tick;
            n_cmp++; if (txd !== fr[i / CLK_DIV]) begin
                n_err++; $display("FAIL single_txd[%0d]: got %b want %b", i, txd, fr[i / CLK_DIV]); end
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_last: got %b want 1", busy); end
        tick;
        n_cmp++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL single_end: busy %b txd %b want 0 1", busy, txd); end
        n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 16'hA55A) begin
            n_err++; $display("FAIL single_rx: got %0d words first %h want 1 a55a", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 16'hxxxx); end
    endtask

    task automatic test_fill_overflow(output int e1);
        clear_rx();
        e1 = 0;
        for (int i = 1; i <= 6; i++) begin
            wr = 1'b1; wdata = 16'(i);
            tick;
            if (i == 1) e1 = cyc;
            if (i == 2) begin
                n_cmp++; if (busy !== 1'b1 || count !== 3'd1) begin
                    n_err++; $display("FAIL fill_e2: busy %b count %0d want 1 1", busy, count); end
            end
            if (i == 5) begin
                n_cmp++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
                    n_err++; $display("FAIL fill_e5: count %0d full %b ovf %b want 4 1 0", count, full, overflow); end
            end
            if (i == 6) begin
                n_cmp++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1) begin
                    n_err++; $display("FAIL fill_e6: count %0d full %b ovf %b want 4 1 1", count, full, overflow); end
            end
        end
        wr = 1'b0;
    endtask

    task automatic test_drain(input int e1);
        for (int t = 0; t < 6 * WORD_T && rx_q.size() < 5; t++) tick;
        n_cmp++; if (rx_q.size() != 5) begin n_err++; $display("FAIL drain_cnt: got %0d want 5", rx_q.size()); end
        for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
            n_cmp++; if (rx_q[k] !== 16'(k + 1) || !rx_ok[k]) begin
                n_err++; $display("FAIL drain_word[%0d]: got %h ok %b want %h", k, rx_q[k], rx_ok[k], 16'(k + 1)); end
            n_cmp++; if (rx_st[k] != e1 + 1 + k * WORD_T) begin
                n_err++; $display("FAIL drain_start[%0d]: got %0d want %0d", k, rx_st[k], e1 + 1 + k * WORD_T); end
        end
        for (int t = 0; t < 2 * WORD_T && busy !== 1'b0; t++) tick;
        n_cmp++; if (busy !== 1'b0 || empty !== 1'b1 || count !== 3'd0 || overflow !== 1'b1) begin
            n_err++; $display("FAIL drain_end: busy %b empty %b count %0d ovf %b want 0 1 0 1", busy, empty, count, overflow); end
    endtask

    task automatic test_simul_push_pop;
        int n;
        clear_rx();
        wr = 1'b1; wdata = 16'hC3E1;
        tick;
        n = cyc;
        wdata = 16'h7E18;
        tick;
        wr = 1'b0;
        n_cmp++; if (count !== 3'd1 || empty !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL simul_count: count %0d empty %b busy %b want 1 0 1", count, empty, busy); end
        for (int t = 0; t < 3 * WORD_T && rx_q.size() < 2; t++) tick;
        n_cmp++; if (rx_q.size() != 2) begin n_err++; $display("FAIL simul_cnt: got %0d want 2", rx_q.size()); end
        else begin
            n_cmp++; if (rx_q[0] !== 16'hC3E1 || rx_q[1] !== 16'h7E18 || !rx_ok[0] || !rx_ok[1]) begin
                n_err++; $display("FAIL simul_order: got %h %h want c3e1 7e18", rx_q[0], rx_q[1]); end
            n_cmp++; if (rx_st[0] != n + 1 || rx_st[1] != n + 1 + WORD_T) begin
                n_err++; $display("FAIL simul_timing: got %0d %0d want %0d %0d", rx_st[0], rx_st[1], n + 1, n + 1 + WORD_T); end
        end
        for (int t = 0; t < 2 * WORD_T && busy !== 1'b0; t++) tick;
    endtask

    task automatic test_pointer_wrap;
        int maxc;
        clear_rx();
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1; wdata = 16'h1234 + 16'(i);
            tick;
            wr = 1'b0;
            maxc = int'(count);
            for (int t = 0; t < WORD_T + 10; t++) begin
                tick;
                if (int'(count) > maxc) maxc = int'(count);
                if (!busy && empty) break;
            end
            n_cmp++; if (maxc != 1) begin n_err++; $display("FAIL wrap_maxcount[%0d]: got %0d want 1", i, maxc); end
        end
        n_cmp++; if (rx_q.size() != 10) begin n_err++; $display("FAIL wrap_cnt: got %0d want 10", rx_q.size()); end
        for (int k = 0; k < 10 && k < rx_q.size(); k++) begin
            n_cmp++; if (rx_q[k] !== 16'h1234 + 16'(k) || !rx_ok[k]) begin
                n_err++; $display("FAIL wrap_word[%0d]: got %h want %h", k, rx_q[k], 16'h1234 + 16'(k)); end
        end
    endtask

    task automatic test_reset_midframe;
        int e1, bad;
        clear_rx();
        e1 = 0;
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; wdata = 16'h1111 * 16'(i + 1);
            tick;
            if (i == 0) e1 = cyc;
        end
        wr = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL mid_queued: got %0d want 2", count); end
        while (cyc < e1 + 15) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_cmp++; if (txd !== 1'b1 || busy !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || full !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: txd %b busy %b count %0d empty %b ovf %b full %b want 1 0 0 1 0 0",
                              txd, busy, count, empty, overflow, full); end
        bad = 0;
        for (int t = 0; t < 200; t++) begin
            tick;
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0 || rx_q.size() != 0) begin
            n_err++; $display("FAIL mid_quiet: active cycles %0d frames %0d want 0 0", bad, rx_q.size()); end
        wr = 1'b1; wdata = 16'hBEEF;
        tick;
        e1 = cyc;
        wr = 1'b0;
        for (int t = 0; t < 2 * WORD_T && rx_q.size() < 1; t++) tick;
        n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 16'hBEEF || rx_st[0] != e1 + 1) begin
            n_err++; $display("FAIL mid_restart: frames %0d word %h start %0d want 1 beef %0d",
                              rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 16'hxxxx, rx_st.size() > 0 ? rx_st[0] : -1, e1 + 1); end
    endtask

    initial begin
        int e1;
        test_reset();
        test_single_word();
        test_fill_overflow(e1);
        test_drain(e1);
        test_simul_push_pop();
        test_pointer_wrap();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
